// File: rtl/write_back.sv
// Final pipeline stage: commits ALU / multiplier results to the register bank
// and CPSR, splitting 64-bit multiply results into two register writes.
module write_back #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_i,
    input  logic [ADDR_W-1:0]   dest_i,
    input  logic [ADDR_W-1:0]   dest_hi_i,
    input  logic                write_dest_do_i,
    input  logic                write_dest_m_i,
    input  logic                long_i,
    input  logic                write_cpsr_i,
    input  logic [DATA_W-1:0]   result_i,
    input  logic [2*DATA_W-1:0] m_result_i,
    input  logic [3:0]          flags_i,
    input  logic [31:0]         cpsr_i,
    output logic                reg_we_o,
    output logic [ADDR_W-1:0]   reg_addr_o,
    output logic [DATA_W-1:0]   reg_data_o,
    output logic                cpsr_we_o,
    output logic [31:0]         cpsr_o,
    output logic                pc_write_o,
    output logic                stall_o
);

    typedef enum logic {
        IDLE,
        HI
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(15);

    state_t              state;
    state_t              state_nx;
    logic                accept;
    logic                go_hi;
    logic [ADDR_W-1:0]   hi_addr;
    logic [DATA_W-1:0]   hi_data;

    logic                we_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [DATA_W-1:0]   data_nx;
    logic                cpsr_we_nx;
    logic [31:0]         cpsr_nx;
    logic                pc_nx;
    logic                stall_nx;

    assign accept = wb_i && !stall_o;
    // The data-op write wins, so a long multiply only splits when it owns the port.
    assign go_hi  = accept && !write_dest_do_i && write_dest_m_i && long_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (go_hi) state_nx = HI;
            HI:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        we_nx      = 1'b0;
        addr_nx    = reg_addr_o;
        data_nx    = reg_data_o;
        cpsr_we_nx = 1'b0;
        cpsr_nx    = cpsr_o;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (write_dest_do_i) begin
                        we_nx   = 1'b1;
                        addr_nx = dest_i;
                        data_nx = result_i;
                    end else if (write_dest_m_i) begin
                        we_nx   = 1'b1;
                        addr_nx = dest_i;
                        data_nx = m_result_i[DATA_W-1:0];
                    end
                    if (write_cpsr_i) begin
                        cpsr_we_nx = 1'b1;
                        cpsr_nx    = {flags_i, cpsr_i[27:0]};
                    end
                end
            end
            HI: begin
                we_nx   = 1'b1;
                addr_nx = hi_addr;
                data_nx = hi_data;
            end
        endcase
        pc_nx    = we_nx && (addr_nx == PC_ADDR);
        stall_nx = (state_nx == HI);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_addr <= '0;
            hi_data <= '0;
        end else if (go_hi) begin
            hi_addr <= dest_hi_i;
            hi_data <= m_result_i[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_we_o   <= 1'b0;
            reg_addr_o <= '0;
            reg_data_o <= '0;
            cpsr_we_o  <= 1'b0;
            cpsr_o     <= '0;
            pc_write_o <= 1'b0;
            stall_o    <= 1'b0;
        end else begin
            reg_we_o   <= we_nx;
            reg_addr_o <= addr_nx;
            reg_data_o <= data_nx;
            cpsr_we_o  <= cpsr_we_nx;
            cpsr_o     <= cpsr_nx;
            pc_write_o <= pc_nx;
            stall_o    <= stall_nx;
        end
    end

endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back: stimulus pushes expected commits,
// a negedge monitor pops and compares every presented write.
module tb_write_back;

    logic        clk;
    logic        rst;
    logic        wb_i;
    logic [3:0]  dest_i;
    logic [3:0]  dest_hi_i;
    logic        write_dest_do_i;
    logic        write_dest_m_i;
    logic        long_i;
    logic        write_cpsr_i;
    logic [31:0] result_i;
    logic [63:0] m_result_i;
    logic [3:0]  flags_i;
    logic [31:0] cpsr_i;
    logic        reg_we_o;
    logic [3:0]  reg_addr_o;
    logic [31:0] reg_data_o;
    logic        cpsr_we_o;
    logic [31:0] cpsr_o;
    logic        pc_write_o;
    logic        stall_o;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        cpsr_we;
        logic [31:0] cpsr;
        logic        pc;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    write_back #(
        .ADDR_W(4),
        .DATA_W(32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_i            (wb_i),
        .dest_i          (dest_i),
        .dest_hi_i       (dest_hi_i),
        .write_dest_do_i (write_dest_do_i),
        .write_dest_m_i  (write_dest_m_i),
        .long_i          (long_i),
        .write_cpsr_i    (write_cpsr_i),
        .result_i        (result_i),
        .m_result_i      (m_result_i),
        .flags_i         (flags_i),
        .cpsr_i          (cpsr_i),
        .reg_we_o        (reg_we_o),
        .reg_addr_o      (reg_addr_o),
        .reg_data_o      (reg_data_o),
        .cpsr_we_o       (cpsr_we_o),
        .cpsr_o          (cpsr_o),
        .pc_write_o      (pc_write_o),
        .stall_o         (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [3:0] addr,
                        input logic [31:0] data, input logic cwe,
                        input logic [31:0] cpsr, input logic pc,
                        input logic stall);
        exp_t e;
        e.we = we; e.addr = addr; e.data = data; e.cpsr_we = cwe;
        e.cpsr = cpsr; e.pc = pc; e.stall = stall;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        wb_i = 0; write_dest_do_i = 0; write_dest_m_i = 0; long_i = 0;
        write_cpsr_i = 0;
    endtask

    // Monitor: every presented register or CPSR write must match the queue head.
    always @(negedge clk) begin
        if (rst && (reg_we_o || cpsr_we_o)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=%h cpsr_we=%b",
                         reg_addr_o, reg_data_o, cpsr_we_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (reg_we_o !== e.we || reg_addr_o !== e.addr ||
                    reg_data_o !== e.data || cpsr_we_o !== e.cpsr_we ||
                    cpsr_o !== e.cpsr || pc_write_o !== e.pc ||
                    stall_o !== e.stall) begin
                    failures++;
                    $display("FAIL commit got we=%b a=%0d d=%h cwe=%b c=%h pc=%b st=%b want we=%b a=%0d d=%h cwe=%b c=%h pc=%b st=%b",
                             reg_we_o, reg_addr_o, reg_data_o, cpsr_we_o,
                             cpsr_o, pc_write_o, stall_o, e.we, e.addr,
                             e.data, e.cpsr_we, e.cpsr, e.pc, e.stall);
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        idle_inputs();
        dest_i = 0; dest_hi_i = 0; result_i = 0; m_result_i = 0;
        flags_i = 0; cpsr_i = 0;

        // Reset held while a valid data op is presented
        wb_i = 1; write_dest_do_i = 1; dest_i = 3; result_i = 32'hDEADBEEF;
        write_cpsr_i = 1; flags_i = 4'b1001; cpsr_i = 32'h0000_00D3;
        repeat (3) step();
        chk("rst_we", {31'd0, reg_we_o}, 0);
        chk("rst_data", reg_data_o, 0);
        chk("rst_cpsr", cpsr_o, 0);
        chk("rst_misc", {28'd0, cpsr_we_o, pc_write_o, stall_o, 1'b0}, 0);

        // Release: the data op is accepted on the next edge
        rst = 1'b1;
        push(1, 3, 32'hDEADBEEF, 1, 32'h9000_00D3, 0, 0);
        step();
        chk("first_write_latency", {31'd0, reg_we_o}, 1);
        idle_inputs();

        // Enables without wb_i do nothing; data and CPSR hold
        write_dest_do_i = 1; write_cpsr_i = 1; dest_i = 8; result_i = 32'h1;
        flags_i = 4'b0000;
        step();
        step();
        chk("idle_we", {31'd0, reg_we_o}, 0);
        chk("idle_cpsr_hold", cpsr_o, 32'h9000_00D3);
        chk("idle_data_hold", reg_data_o, 32'hDEADBEEF);
        idle_inputs();

        // Long multiply r4/r5, conflicting op during the stall is ignored
        wb_i = 1; write_dest_m_i = 1; long_i = 1; dest_i = 4; dest_hi_i = 5;
        m_result_i = 64'h11112222_33334444;
        push(1, 4, 32'h33334444, 0, 32'h9000_00D3, 0, 1);
        push(1, 5, 32'h11112222, 0, 32'h9000_00D3, 0, 0);
        step();
        chk("long_stall_hi", {31'd0, stall_o}, 1);
        write_dest_m_i = 0; long_i = 0; write_dest_do_i = 1; dest_i = 9;
        result_i = 32'h55;
        step();
        chk("long_stall_lo", {31'd0, stall_o}, 0);
        idle_inputs();
        step();
        chk("long_done_we", {31'd0, reg_we_o}, 0);

        // Priority and PC write
        wb_i = 1; write_dest_do_i = 1; write_dest_m_i = 1; dest_i = 15;
        result_i = 32'h100; m_result_i = 64'hFFFF_FFFF_0000_0BAD;
        push(1, 15, 32'h100, 0, 32'h9000_00D3, 1, 0);
        step();
        idle_inputs();
        step();
        chk("pc_pulse_once", {31'd0, pc_write_o}, 0);

        // Same register long multiply with CPSR, then back-to-back data op
        wb_i = 1; write_dest_m_i = 1; long_i = 1; dest_i = 7; dest_hi_i = 7;
        m_result_i = 64'hAAAA0001_BBBB0002; write_cpsr_i = 1;
        flags_i = 4'b0110; cpsr_i = 32'hF000_0010;
        push(1, 7, 32'hBBBB0002, 1, 32'h6000_0010, 0, 1);
        push(1, 7, 32'hAAAA0001, 0, 32'h6000_0010, 0, 0);
        step();
        step();
        idle_inputs();
        wb_i = 1; write_dest_do_i = 1; dest_i = 2; result_i = 32'h2222;
        push(1, 2, 32'h2222, 0, 32'h6000_0010, 0, 0);
        step();
        chk("b2b_addr", {28'd0, reg_addr_o}, 2);
        idle_inputs();
        step();

        // Long multiply whose high half targets r15
        wb_i = 1; write_dest_m_i = 1; long_i = 1; dest_i = 1; dest_hi_i = 15;
        m_result_i = 64'h00000200_00000300;
        push(1, 1, 32'h300, 0, 32'h6000_0010, 0, 1);
        push(1, 15, 32'h200, 0, 32'h6000_0010, 1, 0);
        step();
        step();
        idle_inputs();
        step();

        // Reset during the HI cycle discards the pending r5 write
        wb_i = 1; write_dest_m_i = 1; long_i = 1; dest_i = 4; dest_hi_i = 5;
        m_result_i = 64'h55556666_77778888;
        push(1, 4, 32'h77778888, 0, 32'h6000_0010, 0, 1);
        step();
        idle_inputs();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_we", {31'd0, reg_we_o}, 0);
        chk("midrst_stall", {31'd0, stall_o}, 0);
        chk("midrst_data", reg_data_o, 0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_we", {31'd0, reg_we_o}, 0);
        wb_i = 1; write_dest_do_i = 1; dest_i = 6; result_i = 32'h66;
        push(1, 6, 32'h66, 0, 32'h0, 0, 0);
        step();
        idle_inputs();
        repeat (3) step();

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Final pipeline stage. Consumes the execute stage's outputs: destination register, write-enable flags, ALU result, 64-bit multiplier result and CPSR update request.
- Commits them to the register bank through a single write port and to the CPSR.
- 64-bit (long) multiply results take two write cycles: RdLo, then RdHi. During the second cycle the stage stalls the pipeline.

Parameters:
- ADDR_W, 4, register address width (16 architectural registers).
- DATA_W, 32, register data width; the multiply result is 2*DATA_W wide.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_i  in  1  valid; the stage accepts the inputs below when wb_i=1 and stall_o=0.
- dest_i  in  ADDR_W  destination register (Rd, or RdLo for a long multiply).
- dest_hi_i  in  ADDR_W  RdHi for a long multiply.
- write_dest_do_i  in  1  write the data-operation result to dest_i.
- write_dest_m_i  in  1  write the multiply result to dest_i.
- long_i  in  1  the multiply is long (64-bit); meaningful only with write_dest_m_i.
- write_cpsr_i  in  1  update the CPSR condition flags.
- result_i  in  DATA_W  ALU result.
- m_result_i  in  2*DATA_W  multiplier result.
- flags_i  in  4  NZCV from the ALU/multiplier.
- cpsr_i  in  32  current CPSR.
- reg_we_o  out  1  register-bank write enable.
- reg_addr_o  out  ADDR_W  register-bank write address.
- reg_data_o  out  DATA_W  register-bank write data.
- cpsr_we_o  out  1  CPSR write enable.
- cpsr_o  out  32  new CPSR value.
- pc_write_o  out  1  single-cycle pulse; r15 is being written, so fetch must flush.
- stall_o  out  1  stage busy; upstream holds its outputs.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output is 0. A pending RdHi write is discarded. On rst release, the first edge behaves as IDLE.
- All outputs are registered. A write appears on the edge after the input is accepted (latency 1).
- State IDLE, wb_i=1 and stall_o=0:
  - If write_dest_do_i=1: reg_we_o=1, reg_addr_o=dest_i, reg_data_o=result_i. This has priority over write_dest_m_i when both are set.
  - Else if write_dest_m_i=1: reg_we_o=1, reg_addr_o=dest_i, reg_data_o=m_result_i[DATA_W-1:0].
    - If long_i=1, also capture dest_hi_i and m_result_i[2*DATA_W-1:DATA_W], set stall_o=1 and go to HI.
  - Else: reg_we_o=0.
  - If write_cpsr_i=1: cpsr_we_o=1, cpsr_o={flags_i, cpsr_i[27:0]}. The CPSR is written in the same cycle as the first register write.
  - pc_write_o=1 if reg_we_o is asserted with reg_addr_o=15.
- State IDLE, wb_i=0: reg_we_o=0, cpsr_we_o=0, pc_write_o=0; cpsr_o and reg_data_o hold their values.
- State HI (exactly one cycle):
  - reg_we_o=1, reg_addr_o=captured RdHi, reg_data_o=captured high word; cpsr_we_o=0.
  - pc_write_o=1 if RdHi=15.
  - stall_o falls to 0 on the next edge; return to IDLE.
  - wb_i is ignored while stall_o=1; upstream must hold its values.
- Back-to-back: a new instruction accepted in the cycle stall_o returns to 0 writes on the following edge. The stage never inserts a bubble beyond the single HI cycle.
- RdLo==RdHi: both writes are issued in order, so the high word is the final value.
- stall_o is a registered output, asserted in the same cycle as the RdLo write.
- Enable flags without wb_i=1 have no effect.

Test Plan:
- Reset: hold rst=0 while driving wb_i=1 and write_dest_do_i=1 -> all outputs stay 0. Release rst -> the first accepted write appears one edge later.
- Data op: wb_i=1, write_dest_do_i=1, dest_i=3, result_i=32'hDEADBEEF, write_cpsr_i=1, flags_i=4'b1001, cpsr_i=32'h0000_00D3 -> next edge: reg_we_o=1, reg_addr_o=3, reg_data_o=DEADBEEF, cpsr_we_o=1, cpsr_o=32'h9000_00D3, stall_o=0.
- Long multiply: write_dest_m_i=1, long_i=1, dest_i=4, dest_hi_i=5, m_result_i=64'h11112222_33334444 -> cycle 1: write r4=33334444 with stall_o=1; cycle 2: write r5=11112222; cycle 3: stall_o=0, reg_we_o=0. A conflicting wb_i presented during cycle 2 is ignored.
- PC write and priority: write_dest_do_i=1 and write_dest_m_i=1 with dest_i=15, result_i=32'h100 -> reg_data_o=32'h100 (ALU result wins), pc_write_o high for exactly one cycle.
- Reset mid-operation: assert rst=0 during the HI cycle of a long multiply -> no r5 write occurs; outputs are cleared asynchronously; after release the stage is in IDLE.
- Same register: long multiply with dest_i=dest_hi_i=7 -> two consecutive writes to r7, high word last.
